// File: rtl/alu_pipe.sv
// Registered ALU with a valid/ready handshake and one output register stage.
// Optional accumulate op (sel=111) is enabled by defining ALU_ACC_EN.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             neg_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             carry_r;
  logic             zero_r;
  logic             ovf_r;
  logic             neg_r;

  logic             xfer_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   dif_s;
  logic             shift_big_s;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH:0]   acc_sum_s;
`endif

  // Stage frees up as soon as the held result is being consumed.
  assign in_ready = !out_valid_r || out_ready;
  assign xfer_s   = in_valid && in_ready;

  assign sum_s       = {1'b0, a} + {1'b0, b};
  assign dif_s       = {1'b0, a} - {1'b0, b};
  assign shift_big_s = (b >= WIDTH_V);
`ifdef ALU_ACC_EN
  assign acc_sum_s   = {1'b0, acc_r} + {1'b0, a};
`endif

  // Result and carry/overflow selection for the current opcode.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (sel)
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_XOR: res_s = a ^ b;
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = dif_s[WIDTH-1:0];
        carry_s = dif_s[WIDTH];
        ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_s[WIDTH-1] != a[WIDTH-1]);
      end
      // The whole of b is range-checked, not just the low SHW bits.
      OP_SLL: begin
        if (shift_big_s) res_s = {WIDTH{1'b0}};
        else             res_s = a << b[SHW-1:0];
      end
      OP_SRL: begin
        if (shift_big_s) res_s = {WIDTH{1'b0}};
        else             res_s = a >> b[SHW-1:0];
      end
      OP_ACC: begin
`ifdef ALU_ACC_EN
        if (b[0]) begin
          res_s = a;
        end else begin
          res_s   = acc_sum_s[WIDTH-1:0];
          carry_s = acc_sum_s[WIDTH];
          ovf_s   = (acc_r[WIDTH-1] == a[WIDTH-1]) && (acc_sum_s[WIDTH-1] != a[WIDTH-1]);
        end
`else
        res_s = {WIDTH{1'b0}};
`endif
      end
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // Output register: loads on transfer, otherwise holds; valid drops on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b1;
      ovf_r       <= 1'b0;
      neg_r       <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_r       <= res_s;
      carry_r     <= carry_s;
      zero_r      <= (res_s == {WIDTH{1'b0}});
      ovf_r       <= ovf_s;
      neg_r       <= res_s[WIDTH-1];
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef ALU_ACC_EN
  // Accumulator follows ACC results only, so back-to-back ACCs chain directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (xfer_s && (sel == OP_ACC)) begin
      acc_r <= res_s;
    end
  end
`endif

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign carry_out = carry_r;
  assign zero_flag = zero_r;
  assign ovf_flag  = ovf_r;
  assign neg_flag  = neg_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe (WIDTH=8); honours ALU_ACC_EN.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry_out;
  logic       zero_flag;
  logic       ovf_flag;
  logic       neg_flag;

  int compared = 0;
  int mismatched = 0;

  // Expected {out, carry, zero, ovf, neg}
  logic [11:0] sb_q[$];

  localparam logic [2:0] AND_OP = 3'b000, OR_OP = 3'b001, XOR_OP = 3'b010, ADD_OP = 3'b011;
  localparam logic [2:0] SUB_OP = 3'b100, SLL_OP = 3'b101, SRL_OP = 3'b110, ACC_OP = 3'b111;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry_out(carry_out), .zero_flag(zero_flag),
    .ovf_flag(ovf_flag), .neg_flag(neg_flag)
  );

  always #5 clk = ~clk;

  // Scoreboard: a result presented with out_ready high is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [11:0] exp_v;
      logic [11:0] obs_v;
      obs_v = {out, carry_out, zero_flag, ovf_flag, neg_flag};
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $error("FAIL unexpected_result: got %h required none", obs_v);
      end else begin
        exp_v = sb_q.pop_front();
        assert (obs_v === exp_v) else begin
          mismatched++;
          $error("FAIL result: got %h required %h", obs_v, exp_v);
        end
      end
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] ts,
                      input logic [7:0] eo, input logic [3:0] ef);
    logic ok;
    a = ta; b = tb_v; sel = ts; in_valid = 1'b1;
    sb_q.push_back({eo, ef});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $error("FAIL accept_timeout: got in_ready=0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; sel = 3'b000;
    #3;
    compared++;
    assert ({out_valid, out, carry_out, zero_flag, ovf_flag, neg_flag} === {1'b0, 8'h00, 4'b0100})
    else begin
      mismatched++;
      $error("FAIL reset_state: got %b required %b",
             {out_valid, out, carry_out, zero_flag, ovf_flag, neg_flag}, {1'b0, 8'h00, 4'b0100});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    assert (in_ready === 1'b1) else begin
      mismatched++;
      $error("FAIL ready_after_reset: got %b required 1", in_ready);
    end
    @(posedge clk); #1;

    // Legacy ops, sub/overflow, shifts ({c,z,v,n} flags)
    send(8'h0F, 8'h01, ADD_OP, 8'h10, 4'b0000);
    send(8'hFF, 8'h01, ADD_OP, 8'h00, 4'b1100);
    send(8'hAA, 8'hCC, AND_OP, 8'h88, 4'b0001);
    send(8'hAA, 8'hCC, OR_OP,  8'hEE, 4'b0001);
    send(8'hAA, 8'hCC, XOR_OP, 8'h66, 4'b0000);
    send(8'h03, 8'h05, SUB_OP, 8'hFE, 4'b1001);
    send(8'h80, 8'h01, SUB_OP, 8'h7F, 4'b0010);
    send(8'h7F, 8'h01, ADD_OP, 8'h80, 4'b0011);
    send(8'h81, 8'h01, SLL_OP, 8'h02, 4'b0000);
    send(8'h81, 8'h01, SRL_OP, 8'h40, 4'b0000);
    send(8'h81, 8'h08, SLL_OP, 8'h00, 4'b0100);
    send(8'h81, 8'h07, SRL_OP, 8'h01, 4'b0000);
    send(8'h81, 8'h09, SRL_OP, 8'h00, 4'b0100);
    idle(2);

    // Backpressure: hold the XOR result for three cycles while ADD waits
    out_ready = 1'b0;
    send(8'hF0, 8'h0F, XOR_OP, 8'hFF, 4'b0001);
    a = 8'h01; b = 8'h02; sel = ADD_OP; in_valid = 1'b1;
    sb_q.push_back({8'h03, 4'b0000});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      assert ({in_ready, out_valid, out, carry_out, zero_flag, ovf_flag, neg_flag} === {2'b01, 8'hFF, 4'b0001})
      else begin
        mismatched++;
        $error("FAIL stall_hold: got %b required %b",
               {in_ready, out_valid, out, carry_out, zero_flag, ovf_flag, neg_flag}, {2'b01, 8'hFF, 4'b0001});
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    idle(3);

    // Accumulate chain, back-to-back
`ifdef ALU_ACC_EN
    send(8'h05, 8'h01, ACC_OP, 8'h05, 4'b0000);
    send(8'h03, 8'h00, ACC_OP, 8'h08, 4'b0000);
    send(8'hFA, 8'h00, ACC_OP, 8'h02, 4'b1000);
`else
    send(8'h05, 8'h01, ACC_OP, 8'h00, 4'b0100);
    send(8'h03, 8'h00, ACC_OP, 8'h00, 4'b0100);
    send(8'hFA, 8'h00, ACC_OP, 8'h00, 4'b0100);
`endif
    idle(2);

    // Reset between edges while a result is held
    out_ready = 1'b0;
    send(8'h0F, 8'h01, ADD_OP, 8'h10, 4'b0000);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    compared++;
    assert ({out_valid, zero_flag, out} === {2'b01, 8'h00}) else begin
      mismatched++;
      $error("FAIL reset_mid: got %b required %b", {out_valid, zero_flag, out}, {2'b01, 8'h00});
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_ACC_EN
    send(8'h04, 8'h00, ACC_OP, 8'h04, 4'b0000);
`else
    send(8'h04, 8'h00, ACC_OP, 8'h00, 4'b0100);
`endif
    idle(4);

    compared++;
    assert ({sb_q.size() == 0, out_valid} === 2'b10) else begin
      mismatched++;
      $error("FAIL drain: got pending=%0d out_valid=%b required 0/0", sb_q.size(), out_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
